// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared CPU definitions: memory arbiter FSM state encodings, ALU op codes
// and a small helper that converts a byte address to a word address.
// No ports; imported by the arbiter and its winner-select helper.
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

  // Arbiter FSM states. An access is only ever issued from IDLE; the two
  // response states each last exactly one cycle.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    IF_RESP = 2'b01,
    D_RESP  = 2'b10
  } arb_state_e;

  // ALU operation codes used by the execute stage.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_SLT  = 4'h5,
    ALU_SLTU = 4'h6,
    ALU_SLL  = 4'h7,
    ALU_SRL  = 4'h8,
    ALU_SRA  = 4'h9,
    ALU_LUI  = 4'hA
  } alu_op_e;

  localparam int STARVE_CNT_W = 2;

  // The low two address bits are deliberately dropped: there is no
  // misalignment detection, every access targets the enclosing word.
  function automatic logic [29:0] word_addr(input logic [31:0] byte_addr);
    return byte_addr[31:2];
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// ---------------------------------------------------------------------------
// mem_arb_pick
// Combinational winner selection between the fetch and data requesters.
// Data normally wins on contention; once the data side has been granted
// STARVE_MAX times in a row while fetch waited, fetch wins instead.
// Ports:
//   if_req      in  fetch request
//   d_req       in  data request
//   starve_cnt  in  consecutive data grants while fetch was waiting
//   grant_d     out data port wins this cycle
//   grant_if    out fetch port wins this cycle
// ---------------------------------------------------------------------------
module mem_arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 2
) (
  input  logic                    if_req,
  input  logic                    d_req,
  input  logic [STARVE_CNT_W-1:0] starve_cnt,
  output logic                    grant_d,
  output logic                    grant_if
);

  localparam logic [STARVE_CNT_W-1:0] STARVE_LIMIT = STARVE_CNT_W'(STARVE_MAX);

  logic starved;

  always_comb begin
    starved  = (starve_cnt == STARVE_LIMIT);
    grant_d  = d_req & (~if_req | ~starved);
    grant_if = if_req & (~d_req | starved);
  end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port synchronous memory between instruction fetch and
// data (load/store). Accesses are issued combinationally from IDLE, the
// read data comes back one cycle later in IF_RESP or D_RESP, so throughput
// is at most one access every two cycles. Requesters hold their inputs
// until their valid pulse; nothing is latched here.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   if_req/if_addr                   fetch request and byte address
//   if_rdata/if_valid                fetched word, one-cycle completion
//   d_req/d_wren/d_addr/d_wdata      data request (wren=1 store)
//   d_rdata/d_valid                  load data (0 for stores), completion
//   mem_en/mem_wren/mem_addr/
//   mem_wdata/mem_rdata              memory port (word address)
//   stall                            a request is pending, not yet done
// ---------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        d_req,
  input  logic        d_wren,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        mem_en,
  output logic        mem_wren,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall
);

  localparam logic [STARVE_CNT_W-1:0] STARVE_LIMIT = STARVE_CNT_W'(STARVE_MAX);

  arb_state_e              state_q, state_d;
  logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic                    grant_d, grant_if;

  mem_arb_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .if_req    (if_req),
    .d_req     (d_req),
    .starve_cnt(starve_cnt_q),
    .grant_d   (grant_d),
    .grant_if  (grant_if)
  );

  // Next-state, starvation counter and all outputs. Every output is forced
  // to zero while rst_n is low so an access caught mid-flight by reset never
  // produces a valid pulse or a memory strobe.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    mem_en       = 1'b0;
    mem_wren     = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    if_valid     = 1'b0;
    if_rdata     = '0;
    d_valid      = 1'b0;
    d_rdata      = '0;

    unique case (state_q)
      IDLE: begin
        if (grant_if || grant_d) begin
          mem_en    = 1'b1;
          mem_wren  = d_wren & grant_d;
          mem_addr  = grant_if ? word_addr(if_addr) : word_addr(d_addr);
          mem_wdata = d_wdata;
        end
        if (grant_if) begin
          state_d      = IF_RESP;
          starve_cnt_d = '0;
        end else if (grant_d) begin
          state_d = D_RESP;
          // Only count data grants that actually made fetch wait.
          if (!if_req) begin
            starve_cnt_d = '0;
          end else if (starve_cnt_q < STARVE_LIMIT) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
          end
        end else begin
          starve_cnt_d = '0;
        end
      end
      IF_RESP: begin
        if_valid = 1'b1;
        if_rdata = mem_rdata;
        state_d  = IDLE;
      end
      D_RESP: begin
        d_valid = 1'b1;
        d_rdata = d_wren ? 32'h0 : mem_rdata;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (!rst_n) begin
      mem_en    = 1'b0;
      mem_wren  = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if_valid  = 1'b0;
      if_rdata  = '0;
      d_valid   = 1'b0;
      d_rdata   = '0;
    end

    stall = rst_n & ((if_req & ~if_valid) | (d_req & ~d_valid));
  end

  // FSM state and starvation counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter with a small behavioural synchronous memory.
// Inputs are driven 1 time unit after the rising edge and outputs are
// sampled 1 time unit later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req;
  logic        d_wren;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        mem_en;
  logic        mem_wren;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall;

  int checks;
  int errors;

  logic [31:0] mem [0:63];

  mem_arbiter #(
    .STARVE_MAX(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_valid (if_valid),
    .d_req    (d_req),
    .d_wren   (d_wren),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_valid  (d_valid),
    .mem_en   (mem_en),
    .mem_wren (mem_wren),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .stall    (stall)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous memory: read data appears the cycle after the
  // strobe, writes land on the strobe edge.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wren) mem[mem_addr[5:0]] <= mem_wdata;
      else          mem_rdata <= mem[mem_addr[5:0]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic        i_req,
                               input logic [31:0] i_addr,
                               input logic        dq,
                               input logic        dw,
                               input logic [31:0] da,
                               input logic [31:0] dd);
    if_req  = i_req;
    if_addr = i_addr;
    d_req   = dq;
    d_wren  = dw;
    d_addr  = da;
    d_wdata = dd;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    bit exp_d [6];
    checks    = 0;
    errors    = 0;
    mem_rdata = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4] = 32'h2008_0005;
    mem[5] = 32'h1111_2222;
    exp_d  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    // Reset held with a fetch already requesting: everything stays quiet.
    rst_n = 1'b0;
    applyStimulus(1'b1, 32'h0000_0010, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    checkOutput("rst_mem_en",   32'(mem_en),   32'h0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'h0);
    checkOutput("rst_stall",    32'(stall),    32'h0);
    checkOutput("rst_if_valid", 32'(if_valid), 32'h0);
    checkOutput("rst_d_valid",  32'(d_valid),  32'h0);

    // First cycle out of reset issues the pending fetch.
    rst_n = 1'b1;
    #1;
    checkOutput("fetch_mem_en",   32'(mem_en),   32'h1);
    checkOutput("fetch_mem_wren", 32'(mem_wren), 32'h0);
    checkOutput("fetch_mem_addr", 32'(mem_addr), 32'h4);
    checkOutput("fetch_stall",    32'(stall),    32'h1);
    tick();
    checkOutput("fetch_if_valid", 32'(if_valid), 32'h1);
    checkOutput("fetch_if_rdata", if_rdata,      32'h2008_0005);
    checkOutput("fetch_resp_en",  32'(mem_en),   32'h0);
    checkOutput("fetch_d_valid",  32'(d_valid),  32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Idle with nothing requested.
    tick();
    checkOutput("idle_mem_en",   32'(mem_en),   32'h0);
    checkOutput("idle_mem_addr", 32'(mem_addr), 32'h0);
    checkOutput("idle_stall",    32'(stall),    32'h0);
    checkOutput("idle_if_rdata", if_rdata,      32'h0);

    // Store 0xDEADBEEF to byte 0x40 (word 0x10).
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
    #1;
    checkOutput("sw_mem_en",    32'(mem_en),   32'h1);
    checkOutput("sw_mem_wren",  32'(mem_wren), 32'h1);
    checkOutput("sw_mem_addr",  32'(mem_addr), 32'h10);
    checkOutput("sw_mem_wdata", mem_wdata,     32'hDEAD_BEEF);
    checkOutput("sw_stall",     32'(stall),    32'h1);
    tick();
    checkOutput("sw_d_valid",   32'(d_valid),  32'h1);
    checkOutput("sw_d_rdata",   d_rdata,       32'h0);
    checkOutput("sw_resp_en",   32'(mem_en),   32'h0);
    checkOutput("sw_resp_wren", 32'(mem_wren), 32'h0);

    // Back-to-back load from a misaligned byte address in the same word.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0043, 32'h0);
    tick();
    checkOutput("lw_mem_en",   32'(mem_en),   32'h1);
    checkOutput("lw_mem_wren", 32'(mem_wren), 32'h0);
    checkOutput("lw_mem_addr", 32'(mem_addr), 32'h10);
    tick();
    checkOutput("lw_d_valid",  32'(d_valid),  32'h1);
    checkOutput("lw_d_rdata",  d_rdata,       32'hDEAD_BEEF);

    // Simultaneous requests with a cleared counter: data goes first.
    applyStimulus(1'b1, 32'h0000_0014, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
    tick();
    checkOutput("cont_first_addr", 32'(mem_addr), 32'h10);
    checkOutput("cont_first_wren", 32'(mem_wren), 32'h0);
    checkOutput("cont_stall0",     32'(stall),    32'h1);
    tick();
    checkOutput("cont_d_valid",    32'(d_valid),  32'h1);
    checkOutput("cont_d_rdata",    d_rdata,       32'hDEAD_BEEF);
    checkOutput("cont_if_quiet",   32'(if_valid), 32'h0);
    checkOutput("cont_stall1",     32'(stall),    32'h1);
    applyStimulus(1'b1, 32'h0000_0014, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("cont_if_addr",    32'(mem_addr), 32'h5);
    checkOutput("cont_stall2",     32'(stall),    32'h1);
    checkOutput("cont_d_quiet",    32'(d_valid),  32'h0);
    tick();
    checkOutput("cont_if_valid",   32'(if_valid), 32'h1);
    checkOutput("cont_if_rdata",   if_rdata,      32'h1111_2222);
    checkOutput("cont_stall3",     32'(stall),    32'h0);

    // Both requesting continuously: expected grant order D, D, IF, D, D, IF.
    applyStimulus(1'b1, 32'h0000_0014, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
    for (int g = 0; g < 6; g++) begin
      tick();
      checkOutput($sformatf("starve_en_%0d", g),   32'(mem_en),   32'h1);
      checkOutput($sformatf("starve_addr_%0d", g), 32'(mem_addr),
                  exp_d[g] ? 32'h10 : 32'h5);
      tick();
      checkOutput($sformatf("starve_dv_%0d", g),  32'(d_valid),  32'(exp_d[g]));
      checkOutput($sformatf("starve_ifv_%0d", g), 32'(if_valid), 32'(!exp_d[g]));
    end

    // Reset asserted during a data response: the pulse is dropped.
    tick();
    checkOutput("rmid_issue_addr", 32'(mem_addr), 32'h10);
    tick();
    rst_n = 1'b0;
    applyStimulus(1'b1, 32'h0000_0014, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("rmid_d_valid",  32'(d_valid),  32'h0);
    checkOutput("rmid_d_rdata",  d_rdata,       32'h0);
    checkOutput("rmid_if_valid", 32'(if_valid), 32'h0);
    checkOutput("rmid_mem_en",   32'(mem_en),   32'h0);
    checkOutput("rmid_stall",    32'(stall),    32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("rrel_d_valid",  32'(d_valid),  32'h0);
    checkOutput("rrel_mem_en",   32'(mem_en),   32'h1);
    checkOutput("rrel_mem_addr", 32'(mem_addr), 32'h5);
    checkOutput("rrel_stall",    32'(stall),    32'h1);
    tick();
    checkOutput("rrel_if_valid", 32'(if_valid), 32'h1);
    checkOutput("rrel_if_rdata", if_rdata,      32'h1111_2222);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: rst_n  input  1  reset, synchronous and active-low.
REQ-003 SHALL have ports: if_req in 1 fetch request; if_addr in 32 byte address; if_rdata out 32 fetched word; if_valid out 1 fetch complete.
REQ-004 SHALL have ports: d_req in 1 data request; d_wren in 1 (1=store SW, 0=load LW); d_addr in 32 byte address; d_wdata in 32 store data; d_rdata out 32 load data; d_valid out 1 data complete.
REQ-005 SHALL have ports: mem_en out 1 access strobe; mem_wren out 1 write strobe; mem_addr out 30 word address; mem_wdata out 32; mem_rdata in 32, valid one cycle after a read strobe.
REQ-006 SHALL have port: stall out 1, high while any request is pending and not yet completed.
REQ-007 SHALL have parameter: STARVE_MAX, default 2, max consecutive data grants while fetch waits.

Function
REQ-008 SHALL share one single-port synchronous memory between the fetch port and the data port.
REQ-009 SHALL implement FSM states IDLE, IF_RESP, D_RESP.
REQ-010 SHALL issue accesses only in IDLE.
REQ-011 In IDLE with a winner, SHALL drive mem_en=1, mem_addr=winner addr[31:2], mem_wdata=d_wdata, mem_wren=d_wren&(winner==data), all combinationally.
REQ-012 In IDLE with a winner, SHALL move to IF_RESP or D_RESP on the next edge.
REQ-013 SHALL ignore addr[1:0]; no misalignment detection.
REQ-014 Winner selection: data if only d_req; fetch if only if_req; on contention data, unless starve_cnt==STARVE_MAX, then fetch.
REQ-015 starve_cnt: 2-bit; increments on each data grant while if_req=1; clears on fetch grant or whenever if_req=0 in IDLE; saturates at STARVE_MAX.
REQ-016 In IF_RESP, SHALL pulse if_valid=1 with if_rdata=mem_rdata for exactly one cycle, then return to IDLE.
REQ-017 In D_RESP, SHALL pulse d_valid=1 for exactly one cycle, then return to IDLE.
REQ-018 In D_RESP, d_rdata=mem_rdata for loads; d_rdata=0 for stores.
REQ-019 Outside their response cycle, if_rdata/d_rdata SHALL be 0 and if_valid/d_valid SHALL be 0.
REQ-020 mem_en and mem_wren SHALL be 0 in IF_RESP and D_RESP; throughput is at most one access per 2 cycles.
REQ-021 Requesters hold req, addr, wren and wdata stable until their valid; the arbiter does not latch them.
REQ-022 A requester may assert req in the cycle after its valid; it is arbitrated in that IDLE cycle.
REQ-023 stall = (if_req & ~if_valid) | (d_req & ~d_valid), combinational.
REQ-024 No request in IDLE: all mem_* outputs 0 and the state stays IDLE.

Reset
REQ-025 On a rising clk with rst_n=0: state->IDLE and starve_cnt->0.
REQ-026 Any in-flight access SHALL be dropped with no valid pulse.
REQ-027 While rst_n=0: mem_en=0, mem_wren=0, mem_addr=0, mem_wdata=0, if_valid=0, d_valid=0, if_rdata=0, d_rdata=0, stall=0.
REQ-028 The first access SHALL be issued in the first cycle with rst_n=1.

Structure
REQ-029 State encodings (IDLE=2'b00, IF_RESP=2'b01, D_RESP=2'b10) SHALL live in the shared cpu defines header alongside the ALU op codes.
REQ-030 Winner selection SHALL be one combinational sub-module, mem_arb_pick (inputs if_req, d_req, starve_cnt; output grant_d, grant_if).
REQ-031 The FSM, counter and output muxing SHALL stay in mem_arbiter.

Verification
REQ-032 Fetch only: if_req=1, if_addr=0x0000_0010, mem word 4=0x2008_0005 -> mem_en=1, mem_addr=4 in cycle 0; if_valid=1, if_rdata=0x2008_0005 in cycle 1.
REQ-033 Store then load: SW d_addr=0x40, d_wdata=0xDEAD_BEEF -> mem_wren=1, mem_addr=0x10, d_valid next cycle; then LW d_addr=0x40 -> d_rdata=0xDEAD_BEEF.
REQ-034 Contention, both requesting continuously with STARVE_MAX=2 -> grant order D, D, IF, D, D, IF; no valid ever seen on a non-granted port.
REQ-035 Contention, simultaneous if_req and d_req with starve_cnt=0 -> data wins; fetch completes 2 cycles after d_valid; stall=1 throughout.
REQ-036 Reset mid-access: rst_n=0 during D_RESP -> no d_valid pulse; all outputs 0; after release, a pending if_req is issued in the first rst_n=1 cycle.
